// File: rtl/ntt_sequencer_if.sv
// Handshake bundle between the NTT sequencer and its controller.
// The address/enable FSM also connects here through done_flag and conf.
interface ntt_sequencer_if;
    logic       start;
    logic [1:0] mode;
    logic       abort;
    logic [1:0] done_flag;
    logic [2:0] conf;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, mode, abort, done_flag,
        input  conf, busy, done, err
    );

    modport slave (
        input  start, mode, abort, done_flag,
        output conf, busy, done, err
    );
endinterface

// File: rtl/ntt_sequencer.sv
// Sequences the radix-2 and radix-4 NTT phases. Each phase is followed by a
// pipeline drain. A stuck phase times out into a sticky error state.
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | waiting for start; mode is latched on accept
// R2       | radix-2 phase running, waiting for done_flag 01
// R2_DRAIN | radix-2 pipeline drain, DRAIN cycles
// R4       | radix-4 phase running, waiting for done_flag 10
// R4_DRAIN | radix-4 pipeline drain, DRAIN cycles
// FIN      | single-cycle completion, done pulses
// ERR      | phase timed out; held until abort
module ntt_sequencer #(
    parameter int DRAIN   = 14,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    ntt_sequencer_if.slave bus
);
    localparam int PW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int DW = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PHASE_MAX  = PW'(TIMEOUT);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN - 1);

    typedef enum logic [2:0] {
        IDLE, R2, R2_DRAIN, R4, R4_DRAIN, FIN, ERR
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    mode_q;
    logic [PW-1:0] phase_cnt;
    logic [DW-1:0] drain_cnt;
    logic          err_q;
    logic          accept;
    logic          set_err;
    logic          in_phase;
    logic          in_drain;
    logic          phase_timeout;
    logic          drain_end;
    logic [2:0]    conf;
    logic          busy;
    logic          done;

    assign accept        = (state == IDLE) && bus.start && !bus.abort;
    assign in_phase      = (state == R2) || (state == R4);
    assign in_drain      = (state == R2_DRAIN) || (state == R4_DRAIN);
    assign phase_timeout = (phase_cnt == PHASE_LAST);
    assign drain_end     = (drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        set_err    = 1'b0;
        conf       = 3'b000;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    if (bus.mode[0]) begin
                        state_next = R2;
                    end else if (bus.mode[1]) begin
                        state_next = R4;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            R2: begin
                conf = 3'b001;
                // A matching flag beats a timeout landing on the same cycle.
                if (bus.done_flag == 2'b01 && mode_q[0]) begin
                    state_next = R2_DRAIN;
                end else if (phase_timeout) begin
                    state_next = ERR;
                    set_err    = 1'b1;
                end
            end
            R2_DRAIN: begin
                conf = 3'b011;
                if (drain_end) begin
                    state_next = mode_q[1] ? R4 : FIN;
                end
            end
            R4: begin
                conf = 3'b010;
                if (bus.done_flag == 2'b10) begin
                    state_next = R4_DRAIN;
                end else if (phase_timeout) begin
                    state_next = ERR;
                    set_err    = 1'b1;
                end
            end
            R4_DRAIN: begin
                conf = 3'b100;
                if (drain_end) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (bus.abort) begin
            state_next = IDLE;
            set_err    = 1'b0;
        end
    end

    // Counters restart whenever the state changes, including on abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            if (in_phase && state_next == state) begin
                phase_cnt <= (phase_cnt == PHASE_MAX) ? phase_cnt : phase_cnt + 1'b1;
            end else begin
                phase_cnt <= '0;
            end
            if (in_drain && state_next == state) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 2'b00;
            err_q  <= 1'b0;
        end else if (accept) begin
            mode_q <= bus.mode;
            err_q  <= 1'b0;
        end else if (set_err) begin
            err_q <= 1'b1;
        end
    end

    assign bus.conf = conf;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_ntt_sequencer.sv
// Bench for ntt_sequencer: per-cycle check against an age-based activity
// model, directed scenarios with literal expectations, then random traffic.
module tb_ntt_sequencer;
    localparam int DRAIN   = 14;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ntt_sequencer_if bus ();

    ntt_sequencer #(.DRAIN(DRAIN), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Activity codes: 0 idle, 1 radix-2, 2 radix-4, 3 radix-2 drain,
    // 4 radix-4 drain (these equal conf), 5 finish, 6 error.
    int         m_act  = 0;
    int         m_age  = 0;
    logic       m_err  = 1'b0;
    logic [1:0] m_mode = 2'b00;

    always @(posedge clk or posedge rst) begin : model
        int         nact;
        logic       nerr;
        logic [1:0] nmode;
        if (rst) begin
            m_act  <= 0;
            m_age  <= 0;
            m_err  <= 1'b0;
            m_mode <= 2'b00;
        end else begin
            nact  = m_act;
            nerr  = m_err;
            nmode = m_mode;
            if (bus.abort) begin
                nact = 0;
            end else begin
                case (m_act)
                    0: if (bus.start) begin
                        nmode = bus.mode;
                        nerr  = 1'b0;
                        nact  = bus.mode[0] ? 1 : (bus.mode[1] ? 2 : 5);
                    end
                    1, 2: begin
                        if (bus.done_flag == 2'(m_act)) begin
                            nact = m_act + 2;
                        end else if (m_age + 1 == TIMEOUT) begin
                            nact = 6;
                            nerr = 1'b1;
                        end
                    end
                    3: if (m_age + 1 == DRAIN) nact = m_mode[1] ? 2 : 5;
                    4: if (m_age + 1 == DRAIN) nact = 5;
                    5: nact = 0;
                    default: ;
                endcase
            end
            m_age  <= (nact == m_act) ? m_age + 1 : 0;
            m_act  <= nact;
            m_err  <= nerr;
            m_mode <= nmode;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int hist[8];
    int h0[8];
    int n_done = 0;
    int n_busy = 0;
    int d0 = 0;
    int b0 = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One cycle: compare at negedge against the model, then step to posedge+1.
    task automatic tick();
        logic [5:0] got;
        logic [5:0] exp;
        logic [2:0] e_conf;
        @(negedge clk);
        e_conf = (m_act >= 1 && m_act <= 4) ? 3'(m_act) : 3'd0;
        got = {bus.conf, bus.busy, bus.done, bus.err};
        exp = {e_conf, (m_act != 0), (m_act == 5), m_err};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL cycle conf/busy/done/err: got %b, expected %b (t=%0t)", got, exp, $time);
        end
        hist[bus.conf]++;
        if (bus.done) n_done++;
        if (bus.busy) n_busy++;
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 8; i++) h0[i] = hist[i];
        d0 = n_done;
        b0 = n_busy;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while (bus.busy && k < bound) begin
            tick();
            k++;
        end
        chk("idle_reached", int'(bus.busy), 0);
    endtask

    task automatic wait_conf(input logic [2:0] c, input int bound);
        int k;
        k = 0;
        while (bus.conf != c && k < bound) begin
            tick();
            k++;
        end
        chk("conf_reached", int'(bus.conf), int'(c));
    endtask

    task automatic go(input logic [1:0] m);
        bus.mode  = m;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) hist[i] = 0;
        bus.start     = 1'b0;
        bus.mode      = 2'b00;
        bus.abort     = 1'b0;
        bus.done_flag = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_conf", int'(bus.conf), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        rst = 1'b0;
        tick();

        // radix-2 only, flag after 32 cycles
        snap();
        go(2'b01);
        chk("start_latency_conf", int'(bus.conf), 1);
        repeat (31) tick();
        bus.done_flag = 2'b01;
        tick();
        bus.done_flag = 2'b00;
        wait_idle(100);
        chk("m01_r2_cycles", hist[1] - h0[1], 32);
        chk("m01_drain_cycles", hist[3] - h0[3], 14);
        chk("m01_done", n_done - d0, 1);
        chk("m01_busy_cycles", n_busy - b0, 47);

        // both phases
        snap();
        go(2'b11);
        repeat (9) tick();
        bus.done_flag = 2'b01;
        tick();
        bus.done_flag = 2'b00;
        wait_conf(3'b010, 40);
        repeat (19) tick();
        bus.done_flag = 2'b10;
        tick();
        bus.done_flag = 2'b00;
        wait_idle(100);
        chk("m11_r2_cycles", hist[1] - h0[1], 10);
        chk("m11_r2drain", hist[3] - h0[3], 14);
        chk("m11_r4_cycles", hist[2] - h0[2], 20);
        chk("m11_r4drain", hist[4] - h0[4], 14);
        chk("m11_done", n_done - d0, 1);

        // no phases enabled
        snap();
        go(2'b00);
        wait_idle(5);
        chk("m00_done", n_done - d0, 1);
        chk("m00_busy_cycles", n_busy - b0, 1);

        // flag on the same cycle the timeout would fire
        snap();
        go(2'b01);
        repeat (254) tick();
        bus.done_flag = 2'b01;
        tick();
        bus.done_flag = 2'b00;
        wait_idle(40);
        chk("tie_r2_cycles", hist[1] - h0[1], 255);
        chk("tie_err", int'(bus.err), 0);
        chk("tie_done", n_done - d0, 1);

        // radix-4 timeout, abort, restart clears err
        snap();
        go(2'b10);
        repeat (255) tick();
        chk("to_r4_cycles", hist[2] - h0[2], 255);
        chk("to_err", int'(bus.err), 1);
        chk("to_conf", int'(bus.conf), 0);
        chk("to_busy", int'(bus.busy), 1);
        repeat (3) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("to_abort_busy", int'(bus.busy), 0);
        chk("to_abort_err", int'(bus.err), 1);
        go(2'b01);
        chk("restart_err", int'(bus.err), 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;

        // abort in the 5th radix-2 drain cycle
        snap();
        go(2'b01);
        repeat (4) tick();
        bus.done_flag = 2'b01;
        tick();
        bus.done_flag = 2'b00;
        repeat (4) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab_busy", int'(bus.busy), 0);
        chk("ab_drain_cycles", hist[3] - h0[3], 5);
        chk("ab_done", n_done - d0, 0);
        go(2'b01);
        chk("ab_restart_conf", int'(bus.conf), 1);
        repeat (2) tick();
        bus.done_flag = 2'b01;
        tick();
        bus.done_flag = 2'b00;
        wait_idle(40);
        chk("ab_restart_done", n_done - d0, 1);

        // start ignored while busy; start+abort dropped in idle
        snap();
        go(2'b10);
        repeat (5) tick();
        bus.mode  = 2'b01;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_start_conf", int'(bus.conf), 2);
        bus.done_flag = 2'b10;
        tick();
        bus.done_flag = 2'b00;
        wait_idle(40);
        chk("busy_start_no_r2", hist[1] - h0[1], 0);
        bus.mode  = 2'b01;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_busy", int'(bus.busy), 0);
        chk("start_abort_conf", int'(bus.conf), 0);

        // asynchronous reset mid-run
        snap();
        go(2'b11);
        repeat (20) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_conf", int'(bus.conf), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_no_done", n_done - d0, 0);

        // random traffic with varying done_flag density
        for (int seg = 0; seg < 9; seg++) begin
            int pct;
            pct = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 5 : 40);
            for (int c = 0; c < 600; c++) begin
                bus.start     = ($urandom_range(0, 3) == 0);
                bus.mode      = 2'($urandom_range(0, 3));
                bus.abort     = ($urandom_range(0, 299) == 0);
                bus.done_flag = (int'($urandom_range(0, 99)) < pct) ? 2'($urandom_range(0, 3)) : 2'b00;
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
